tmr0_prescaler: RTL

//  Timer0 (RTCC) peripheral for the PIC16C5x core: OPTION register, 8-bit prescaler, 8-bit TMR0 counter.

---
 rtl/tmr0_prescaler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/tmr0_prescaler.sv
// Timer0 (RTCC) for the PIC16C5x: OPTION register, 8-bit prescaler, 8-bit TMR0.
// Define TMR0_OVF_FLAG_EN to build the sticky overflow flag (ovfFlag/ovfClr).
module tmr0_prescaler #(
    parameter int         TMR0_WIDTH = 8,
    parameter int         PRE_WIDTH  = 8,
    parameter logic [5:0] OPT_RST    = 6'h3F
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cycleTick,
    input  logic                  t0cki,
    input  logic                  optionWe,
    input  logic [5:0]            optionIn,
    input  logic                  tmr0We,
    input  logic [TMR0_WIDTH-1:0] tmr0In,
    input  logic                  ovfClr,
    output logic [TMR0_WIDTH-1:0] tmr0Out,
    output logic [5:0]            optionOut,
    output logic                  tmr0Ovf,
    output logic                  ovfFlag
);

    logic [5:0]            opt_q, opt_d;
    logic [PRE_WIDTH-1:0]  pre_q, pre_d;
    logic [TMR0_WIDTH-1:0] tmr_q, tmr_d;
    logic [1:0]            inh_q, inh_d;
    logic                  ovf_q, ovf_d;
    logic                  s1_q, s2_q, s3_q;

    logic                  t0cs, t0se, psa;
    logic [2:0]            ps;
    logic [PRE_WIDTH-1:0]  mask;
    logic                  pin_ev, ev, tick;

    assign t0cs = opt_q[5];
    assign t0se = opt_q[4];
    assign psa  = opt_q[3];
    assign ps   = opt_q[2:0];

    // Third stage only provides edge history; the synced level is s2_q.
    assign pin_ev = t0se ? (s3_q & ~s2_q) : (s2_q & ~s3_q);
    assign ev     = t0cs ? pin_ev : cycleTick;
    assign mask   = PRE_WIDTH'((32'd2 << ps) - 32'd1);

    always_comb begin
        opt_d = opt_q;
        pre_d = pre_q;
        tmr_d = tmr_q;
        inh_d = inh_q;
        ovf_d = 1'b0;
        tick  = 1'b0;
        if (psa) begin
            tick  = ev;
            pre_d = '0;
        end else begin
            tick = ev && ((pre_q & mask) == mask);
            if (ev) begin
                pre_d = pre_q + PRE_WIDTH'(1);
            end
        end
        if (tmr0We || optionWe) begin
            pre_d = '0;
        end
        if (optionWe) begin
            opt_d = optionIn;
        end
        if (tmr0We) begin
            tmr_d = tmr0In;
            inh_d = 2'd2;
        end else if (tick) begin
            if (inh_q != 2'd0) begin
                inh_d = inh_q - 2'd1;
            end else begin
                tmr_d = tmr_q + TMR0_WIDTH'(1);
                ovf_d = (tmr_q == '1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opt_q <= OPT_RST;
            pre_q <= '0;
            tmr_q <= '0;
            inh_q <= 2'd0;
            ovf_q <= 1'b0;
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            s3_q  <= 1'b0;
        end else begin
            opt_q <= opt_d;
            pre_q <= pre_d;
            tmr_q <= tmr_d;
            inh_q <= inh_d;
            ovf_q <= ovf_d;
            s1_q  <= t0cki;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
        end
    end

    assign tmr0Out   = tmr_q;
    assign optionOut = opt_q;
    assign tmr0Ovf   = ovf_q;

`ifdef TMR0_OVF_FLAG_EN
    logic flag_q, flag_d;

    // Setting covers both the pulse edge and the pulse clk so a clear cannot race it.
    always_comb begin
        flag_d = flag_q;
        if (ovf_d || ovf_q) begin
            flag_d = 1'b1;
        end else if (ovfClr) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign ovfFlag = flag_q;
`else
    logic unused_clr;
    assign unused_clr = ovfClr;
    assign ovfFlag    = 1'b0;
`endif

endmodule
